// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock flexible FIFO.
// Read-mode encoding plus the non-power-of-two pointer wrap rule.
package fifo_pkg;

  typedef enum logic {
    SHOW_AHEAD = 1'b0,
    REGISTERED = 1'b1
  } fifo_rd_mode_t;

  function automatic int unsigned next_ptr_wrap(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Wrapping pointer for an arbitrary-depth FIFO.
// Counts 0..DEPTH-1 and returns to 0, with a synchronous clear.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_next;

  // Explicit compare against DEPTH-1 so odd depths wrap correctly
  always_comb begin
    w_next = AW'(next_ptr_wrap(32'(r_ptr), DEPTH));
  end

  // Pointer register: clear dominates advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else if (i_enable) begin
      r_ptr <= w_next;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with any depth, selectable read mode,
// occupancy count, synchronous flush and sticky error flags.
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int    DATA_WIDTH       = 8,
  parameter int    DEPTH            = 10,
  parameter int    ALMOST_WR_MARGIN = 1,
  parameter int    ALMOST_RD_MARGIN = 1,
  parameter int    RD_MODE          = 0,
  parameter string INSTANCE_NAME    = "DEADF1F0",
  parameter int    CW               = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_full,
  output logic                  o_wr_almost_full,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_empty,
  output logic                  o_rd_almost_empty,
  output logic [CW-1:0]         o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam fifo_rd_mode_t MODE =
    (RD_MODE == 1) ? REGISTERED : SHOW_AHEAD;

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_flex: DEPTH must be >= 2");
  end
  if (ALMOST_WR_MARGIN >= DEPTH) begin : g_bad_wr_margin
    $error("fifo_sync_flex: ALMOST_WR_MARGIN must be < DEPTH");
  end
  if (ALMOST_RD_MARGIN >= DEPTH) begin : g_bad_rd_margin
    $error("fifo_sync_flex: ALMOST_RD_MARGIN must be < DEPTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         w_wr_ptr;
  logic [AW-1:0]         w_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  assign w_wr_acc = i_write & ~r_full  & ~i_flush;
  assign w_rd_acc = i_read  & ~r_empty & ~i_flush;

  fifo_ptr_wrap #(
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) u_wr_ptr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (i_flush),
    .i_enable (w_wr_acc),
    .o_ptr    (w_wr_ptr)
  );

  fifo_ptr_wrap #(
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) u_rd_ptr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (i_flush),
    .i_enable (w_rd_acc),
    .o_ptr    (w_rd_ptr)
  );

  // Next occupancy; a simultaneous read and write cancel out
  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else begin
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Count and status flags, all derived from the next count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
    end else begin
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_afull  <= (w_count_nxt >= CW'(DEPTH - ALMOST_WR_MARGIN));
      r_empty  <= (w_count_nxt == '0);
      r_aempty <= (w_count_nxt <= CW'(ALMOST_RD_MARGIN));
    end
  end

  // Sticky error flags; only reset or flush clear them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (i_flush) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (i_write && r_full) begin
        r_ovf <= 1'b1;
      end
      if (i_read && r_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  // Storage array is deliberately left unreset
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_ptr] <= i_wr_data;
    end
  end

  if (MODE == REGISTERED) begin : g_rd_reg
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Capture the head word on each accepted read, else hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_rd_data <= '0;
      end else if (w_rd_acc) begin
        r_rd_data <= r_mem[w_rd_ptr];
      end
    end

    assign o_rd_data = r_rd_data;
  end else begin : g_rd_show
    assign o_rd_data = r_mem[w_rd_ptr];
  end

`ifndef SYNTHESIS
  // Flag dropped requests with the instance tag in simulation
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && i_write && r_full) begin
      $display("%s: write attempted while full, dropped",
               INSTANCE_NAME);
    end
    if (i_rst_n && !i_flush && i_read && r_empty) begin
      $display("%s: read attempted while empty, ignored",
               INSTANCE_NAME);
    end
  end
`endif

  assign o_wr_full         = r_full;
  assign o_wr_almost_full  = r_afull;
  assign o_rd_empty        = r_empty;
  assign o_rd_almost_empty = r_aempty;
  assign o_count           = r_count;
  assign o_overflow        = r_ovf;
  assign o_underflow       = r_udf;

endmodule
